// File: rtl/tone_note_decoder.sv
// tone_note_decoder: measures the period of a square-wave tone and locks onto the matching note M1..M7.
// Define DUTY_CHECK_EN to reject tones whose low time is outside 25%..75% of the period.
module tone_note_decoder #(
   parameter logic [16:0] M1       = 17'd95600,
   parameter logic [16:0] M2       = 17'd85150,
   parameter logic [16:0] M3       = 17'd75850,
   parameter logic [16:0] M4       = 17'd71600,
   parameter logic [16:0] M5       = 17'd63750,
   parameter logic [16:0] M6       = 17'd56800,
   parameter logic [16:0] M7       = 17'd50600,
   parameter logic [16:0] TOL      = 17'd2000,
   parameter int          STABLE_N = 4,
   parameter logic [16:0] TIMEOUT  = 17'd120000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tone_in,
   output logic [2:0]  note_code,
   output logic        note_valid,
   output logic [16:0] period_out,
   output logic        locked
);
   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
   localparam logic [7:0] SN = 8'(STABLE_N);
   state_t      r_state, w_state_n;
   logic [1:0]  r_sync;
   logic        r_prev;
   logic [16:0] r_per_cnt, w_per_n, r_period, w_period_n;
   logic [2:0]  r_cand, w_cand_n, r_note, w_note_n, w_raw, w_class;
   logic [7:0]  r_cnt, w_cnt_n, w_m_cnt;
   logic        r_valid, w_valid_n, r_locked, w_lock_n;
   logic        w_fall, w_tmo, w_hit, w_stable;
   logic [16:0] w_p;
   function automatic logic near(input logic [16:0] p, input logic [16:0] m);
      return ((p >= m) ? p - m : m - p) <= TOL;
   endfunction
   assign w_fall = r_prev & ~r_sync[1];
   assign w_p    = r_per_cnt + 17'd1;
   assign w_tmo  = (r_per_cnt == TIMEOUT) & ~w_fall;
   assign w_raw  = near(w_p, M1) ? 3'd1 : near(w_p, M2) ? 3'd2 : near(w_p, M3) ? 3'd3 :
                   near(w_p, M4) ? 3'd4 : near(w_p, M5) ? 3'd5 : near(w_p, M6) ? 3'd6 :
                   near(w_p, M7) ? 3'd7 : 3'd0;
`ifdef DUTY_CHECK_EN
   logic        w_rise;
   logic [16:0] r_low_cnt, r_low;
   logic [18:0] w_l4, w_p3;
   assign w_rise  = ~r_prev & r_sync[1];
   assign w_l4    = {r_low, 2'b00};
   assign w_p3    = {2'b00, w_p} + {1'b0, w_p, 1'b0};
   assign w_class = (w_l4 >= {2'b00, w_p} && w_l4 <= w_p3) ? w_raw : 3'd0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_low_cnt <= '0;
         r_low     <= '0;
      end else begin
         r_low_cnt <= w_fall ? 17'd0 : (&r_low_cnt) ? r_low_cnt : r_low_cnt + 17'd1;
         if (w_rise) r_low <= r_low_cnt + 17'd1;
      end
   end
`else
   assign w_class = w_raw;
`endif
   assign w_hit    = (w_class == r_cand) && (w_class != 3'd0);
   assign w_m_cnt  = w_hit ? ((r_cnt == SN) ? r_cnt : r_cnt + 8'd1) : {7'd0, w_class != 3'd0};
   assign w_stable = (w_m_cnt == SN) && (w_class != 3'd0);
   assign w_per_n  = (r_state == IDLE || w_fall) ? 17'd0 :
                     (r_per_cnt == TIMEOUT) ? TIMEOUT : r_per_cnt + 17'd1;
   always_comb begin
      w_state_n  = r_state;
      w_note_n   = r_note;
      w_valid_n  = 1'b0;
      w_lock_n   = r_locked;
      w_cand_n   = r_cand;
      w_cnt_n    = r_cnt;
      w_period_n = r_period;
      case (r_state)
         IDLE: if (w_fall) w_state_n = MEASURE;
         MEASURE, LOCKED:
            if (w_fall) begin
               w_period_n = w_p;
               w_cand_n   = w_class;
               w_cnt_n    = w_m_cnt;
               if (w_stable && w_class != r_note) begin
                  w_note_n  = w_class;
                  w_lock_n  = 1'b1;
                  w_valid_n = 1'b1;
                  w_state_n = LOCKED;
               end
            end else if (w_tmo) begin
               w_state_n = IDLE;
               w_cand_n  = 3'd0;
               w_cnt_n   = 8'd0;
               w_note_n  = 3'd0;
               w_lock_n  = 1'b0;
               w_valid_n = (r_state == LOCKED);
            end
         default: w_state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync    <= 2'b11;
         r_prev    <= 1'b1;
         r_state   <= IDLE;
         r_per_cnt <= '0;
         r_period  <= '0;
         r_cand    <= '0;
         r_cnt     <= '0;
         r_note    <= '0;
         r_valid   <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], tone_in};
         r_prev    <= r_sync[1];
         r_state   <= w_state_n;
         r_per_cnt <= w_per_n;
         r_period  <= w_period_n;
         r_cand    <= w_cand_n;
         r_cnt     <= w_cnt_n;
         r_note    <= w_note_n;
         r_valid   <= w_valid_n;
         r_locked  <= w_lock_n;
      end
   end
   assign note_code  = r_note;
   assign note_valid = r_valid;
   assign period_out = r_period;
   assign locked     = r_locked;
endmodule

// File: tb/tb_tone_note_decoder.sv
// tb_tone_note_decoder: directed tone sequences against tone_note_decoder with periods scaled /100.
module tb_tone_note_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tone_in = 1'b1;
   logic [2:0]  note_code;
   logic        note_valid;
   logic [16:0] period_out;
   logic        locked;
   int checks = 0, fails = 0;
   int cyc = 0, pulses = 0, pulse_cyc = 0, last_fall = 0, p0 = 0, f5 = 0;
   tone_note_decoder #(
      .M1(17'd956), .M2(17'd851), .M3(17'd758), .M4(17'd716), .M5(17'd637),
      .M6(17'd568), .M7(17'd506), .TOL(17'd20), .STABLE_N(4), .TIMEOUT(17'd1200)
   ) dut (
      .clk(clk), .rst(rst), .tone_in(tone_in), .note_code(note_code),
      .note_valid(note_valid), .period_out(period_out), .locked(locked)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (note_valid) begin
      pulses++;
      pulse_cyc = cyc;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic tone(input int per, input int low, input int n);
      for (int i = 0; i < n; i++) begin
         tone_in = 1'b0;
         last_fall = cyc;
         repeat (low) @(negedge clk);
         tone_in = 1'b1;
         repeat (per - low) @(negedge clk);
      end
   endtask
   task automatic quiet();
      tone_in = 1'b1;
      repeat (1300) @(negedge clk);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_note", 32'(note_code), 0);
      check("rst_valid", 32'(note_valid), 0);
      check("rst_period", 32'(period_out), 0);
      check("rst_locked", 32'(locked), 0);
      rst = 1'b0;
      @(negedge clk);
      p0 = pulses;
      tone(758, 379, 4);
      check("m3_4falls_note", 32'(note_code), 0);
      tone(758, 379, 1);
      f5 = last_fall;
      tone(758, 379, 1);
      check("m3_note", 32'(note_code), 3);
      check("m3_locked", 32'(locked), 1);
      check("m3_period", 32'(period_out), 758);
      check("m3_pulses", 32'(pulses - p0), 1);
      check("m3_pulse_cyc", 32'(pulse_cyc), 32'(f5 + 3));
      quiet();
      tone(956, 478, 5);
      check("m1_note", 32'(note_code), 1);
      p0 = pulses;
      tone(851, 425, 4);
      check("m2_hold_note", 32'(note_code), 1);
      check("m2_hold_pulses", 32'(pulses - p0), 0);
      tone(851, 425, 1);
      check("m2_note", 32'(note_code), 2);
      check("m2_pulses", 32'(pulses - p0), 1);
      check("m2_period", 32'(period_out), 851);
      quiet();
      p0 = pulses;
      tone(800, 400, 10);
      check("gap_note", 32'(note_code), 0);
      check("gap_pulses", 32'(pulses - p0), 0);
      check("gap_period", 32'(period_out), 800);
      quiet();
      check("gap_tmo_pulses", 32'(pulses - p0), 0);
      tone(637, 318, 5);
      check("m5_note", 32'(note_code), 5);
      p0 = pulses;
      quiet();
      check("tmo_note", 32'(note_code), 0);
      check("tmo_locked", 32'(locked), 0);
      check("tmo_pulses", 32'(pulses - p0), 1);
      check("tmo_pulse_cyc", 32'(pulse_cyc), 32'(last_fall + 1204));
      quiet();
      tone(716, 358, 5);
      check("m4_note", 32'(note_code), 4);
      repeat (100) @(negedge clk);
      p0 = pulses;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_note", 32'(note_code), 0);
      check("mid_rst_locked", 32'(locked), 0);
      check("mid_rst_period", 32'(period_out), 0);
      check("mid_rst_valid", 32'(note_valid), 0);
      repeat (5) @(negedge clk);
      check("mid_rst_pulses", 32'(pulses - p0), 0);
      tone(716, 358, 4);
      check("relock_4falls", 32'(note_code), 0);
      tone(716, 358, 1);
      check("relock_note", 32'(note_code), 4);
      check("relock_pulses", 32'(pulses - p0), 1);
`ifdef DUTY_CHECK_EN
      quiet();
      tone(568, 57, 8);
      check("duty10_note", 32'(note_code), 0);
      tone(568, 284, 6);
      check("duty50_note", 32'(note_code), 6);
`endif
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
